// File: rtl/alu_req_driver_pkg.sv
// Shared constants, ALU control codes and FSM state encoding for the ALU request driver.
package alu_req_driver_pkg;

   localparam int DW = 32;
   localparam int CW = 4;

   localparam logic [CW-1:0] ALU_OR  = 4'b0000;
   localparam logic [CW-1:0] ALU_AND = 4'b0001;
   localparam logic [CW-1:0] ALU_ADD = 4'b0010;
   localparam logic [CW-1:0] ALU_SUB = 4'b0110;
   localparam logic [CW-1:0] ALU_SLT = 4'b0111;
   localparam logic [CW-1:0] ALU_NOR = 4'b1101;
   localparam logic [CW-1:0] MUL_OP  = 4'b1000;

   localparam int MUL_STEPS = 32;
   localparam int CNT_W     = $clog2(MUL_STEPS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_RESP
   } state_e;

   function automatic logic isAluCode(input logic [CW-1:0] op);
      return (op == ALU_OR)  || (op == ALU_AND) || (op == ALU_ADD) ||
             (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_NOR);
   endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// Request, response and ALU-side signals of the driver; master is the driver, slave its environment.
interface alu_req_driver_if;
   import alu_req_driver_pkg::*;

   logic          req_valid_i;
   logic          req_ready_o;
   logic [CW-1:0] req_op_i;
   logic [DW-1:0] req_a_i;
   logic [DW-1:0] req_b_i;
   logic [DW-1:0] alu_src1_o;
   logic [DW-1:0] alu_src2_o;
   logic [CW-1:0] alu_ctrl_o;
   logic [DW-1:0] alu_result_i;
   logic          alu_zero_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_result_o;
   logic          rsp_zero_o;
   logic          rsp_err_o;

   modport master (
      input  req_valid_i, req_op_i, req_a_i, req_b_i,
      output req_ready_o,
      output alu_src1_o, alu_src2_o, alu_ctrl_o,
      input  alu_result_i, alu_zero_i,
      output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o,
      input  rsp_ready_i
   );

   modport slave (
      output req_valid_i, req_op_i, req_a_i, req_b_i,
      input  req_ready_o,
      input  alu_src1_o, alu_src2_o, alu_ctrl_o,
      output alu_result_i, alu_zero_i,
      input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o,
      output rsp_ready_i
   );

endinterface

// File: rtl/alu_req_driver_mul_seq.sv
// Shift-add multiply datapath: holds accumulator, shifted multiplicand, multiplier and step count.
// Exposes next-cycle operands so the controller can register them straight onto the ALU inputs.
module alu_mul_seq
   import alu_req_driver_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          step_i,
   input  logic [DW-1:0] mcand_i,
   input  logic [DW-1:0] mplier_i,
   input  logic [DW-1:0] sum_i,
   output logic [DW-1:0] accNext_o,
   output logic [DW-1:0] addendNext_o,
   output logic          last_o
);

   logic [DW-1:0]    acc_q, acc_d;
   logic [DW-1:0]    mcand_q, mcand_d;
   logic [DW-1:0]    mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = mcand_i;
         mplier_d = mplier_i;
         cnt_d    = '0;
      end else if (step_i) begin
         acc_d    = sum_i;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   // Addend for the next ADD is the multiplicand gated by the next multiplier LSB.
   assign accNext_o    = acc_d;
   assign addendNext_o = mplier_d[0] ? mcand_d : '0;
   assign last_o       = (cnt_q == CNT_W'(MUL_STEPS - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_req_driver.sv
// Initiator for the combinational EX-stage ALU: one outstanding request, registered ALU operands,
// and a 32-step multiply built from repeated ALU ADDs.
module alu_req_driver
   import alu_req_driver_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   alu_req_driver_if.master bus
);

   state_e        state_q;
   logic          reqReady_q;
   logic [DW-1:0] aluSrc1_q;
   logic [DW-1:0] aluSrc2_q;
   logic [CW-1:0] aluCtrl_q;
   logic          rspValid_q;
   logic [DW-1:0] rspResult_q;
   logic          rspZero_q;
   logic          rspErr_q;

   logic          mulLoad;
   logic          mulStep;
   logic [DW-1:0] mulAccNext;
   logic [DW-1:0] mulAddendNext;
   logic          mulLast;

   assign mulLoad = (state_q == ST_IDLE) && bus.req_valid_i && (bus.req_op_i == MUL_OP);
   assign mulStep = (state_q == ST_MUL);

   alu_mul_seq u_mulSeq (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (mulLoad),
      .step_i       (mulStep),
      .mcand_i      (bus.req_a_i),
      .mplier_i     (bus.req_b_i),
      .sum_i        (bus.alu_result_i),
      .accNext_o    (mulAccNext),
      .addendNext_o (mulAddendNext),
      .last_o       (mulLast)
   );

   assign bus.req_ready_o  = reqReady_q;
   assign bus.alu_src1_o   = aluSrc1_q;
   assign bus.alu_src2_o   = aluSrc2_q;
   assign bus.alu_ctrl_o   = aluCtrl_q;
   assign bus.rsp_valid_o  = rspValid_q;
   assign bus.rsp_result_o = rspResult_q;
   assign bus.rsp_zero_o   = rspZero_q;
   assign bus.rsp_err_o    = rspErr_q;

   // ALU operands only change on entry to EXEC/MUL and during MUL, so they hold in IDLE and RESP.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         reqReady_q  <= 1'b1;
         aluSrc1_q   <= '0;
         aluSrc2_q   <= '0;
         aluCtrl_q   <= '0;
         rspValid_q  <= 1'b0;
         rspResult_q <= '0;
         rspZero_q   <= 1'b0;
         rspErr_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid_i && reqReady_q) begin
                  reqReady_q <= 1'b0;
                  if (isAluCode(bus.req_op_i)) begin
                     aluSrc1_q <= bus.req_a_i;
                     aluSrc2_q <= bus.req_b_i;
                     aluCtrl_q <= bus.req_op_i;
                     state_q   <= ST_EXEC;
                  end else if (bus.req_op_i == MUL_OP) begin
                     aluSrc1_q <= mulAccNext;
                     aluSrc2_q <= mulAddendNext;
                     aluCtrl_q <= ALU_ADD;
                     state_q   <= ST_MUL;
                  end else begin
                     rspResult_q <= '0;
                     rspZero_q   <= 1'b1;
                     rspErr_q    <= 1'b1;
                     rspValid_q  <= 1'b1;
                     state_q     <= ST_RESP;
                  end
               end
            end
            ST_EXEC: begin
               rspResult_q <= bus.alu_result_i;
               rspZero_q   <= bus.alu_zero_i;
               rspErr_q    <= 1'b0;
               rspValid_q  <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_MUL: begin
               if (mulLast) begin
                  rspResult_q <= bus.alu_result_i;
                  rspZero_q   <= (bus.alu_result_i == '0);
                  rspErr_q    <= 1'b0;
                  rspValid_q  <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  aluSrc1_q <= mulAccNext;
                  aluSrc2_q <= mulAddendNext;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) begin
                  rspValid_q <= 1'b0;
                  reqReady_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_driver.sv
// Randomised scoreboard bench for alu_req_driver with a behavioural ALU attached to its ALU port.
module tb_alu_req_driver;
   import alu_req_driver_pkg::*;

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic        err;
      int          latency;
   } exp_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cycleCnt = 0;
   int   readyMode = 1;
   logic [3:0] lastCtrl = 4'b0000;
   exp_t expQ[$];

   logic [3:0] legalOps[6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT};
   logic [3:0] illegalOps[9] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15};

   always #5 clk = ~clk;

   alu_req_driver_if bus();

   alu_req_driver dut (
      .clk_i (clk),
      .rst_i (rstN),
      .bus   (bus)
   );

   // Environment ALU: combinational, unsigned SLT
   always_comb begin
      case (bus.alu_ctrl_o)
         ALU_ADD: bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
         ALU_SUB: bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
         ALU_AND: bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
         ALU_OR:  bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
         ALU_NOR: bus.alu_result_i = ~(bus.alu_src1_o | bus.alu_src2_o);
         ALU_SLT: bus.alu_result_i = (bus.alu_src1_o < bus.alu_src2_o) ? 32'd1 : 32'd0;
         default: bus.alu_result_i = 32'd0;
      endcase
      bus.alu_zero_i = (bus.alu_result_i == 32'd0);
   end

   always @(posedge clk) cycleCnt++;

   // Response-ready driver: 0 = hold low, 1 = hold high, 2 = random
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       bus.rsp_ready_i = 1'b0;
         1:       bus.rsp_ready_i = 1'b1;
         default: bus.rsp_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   function automatic exp_t refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.err = 1'b0;
      e.latency = 2;
      case (op)
         ALU_ADD: e.result = a + b;
         ALU_SUB: e.result = a - b;
         ALU_AND: e.result = a & b;
         ALU_OR:  e.result = a | b;
         ALU_NOR: e.result = ~(a | b);
         ALU_SLT: e.result = (a < b) ? 32'd1 : 32'd0;
         MUL_OP: begin
            e.result = a * b;
            e.latency = 33;
         end
         default: begin
            e.result = 32'd0;
            e.err = 1'b1;
            e.latency = 1;
         end
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, actual, required, $time);
      end
   endtask

   // Latency runs from the cycle the request handshake is presented to the first cycle rsp_valid is seen.
   int acceptCycle = 0;
   int firstValidCycle = 0;
   bit seenValid = 1'b0;

   always @(negedge clk) begin
      if (!rstN) begin
         seenValid = 1'b0;
      end else begin
         if (bus.req_valid_i && bus.req_ready_o) acceptCycle = cycleCnt;
         if (bus.rsp_valid_o && !seenValid) begin
            seenValid = 1'b1;
            firstValidCycle = cycleCnt;
         end
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            seenValid = 1'b0;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp: actual=%h required=no response", bus.rsp_result_o);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("rsp_result", bus.rsp_result_o, e.result);
               checkOutput("rsp_zero", 32'(bus.rsp_zero_o), 32'(e.zero));
               checkOutput("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
               checkOutput("rsp_latency", 32'(firstValidCycle - acceptCycle), 32'(e.latency));
            end
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit accepted;
      e = refModel(op, a, b);
      accepted = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = op;
      bus.req_a_i     = a;
      bus.req_b_i     = b;
      for (int i = 0; i < 400 && !accepted; i++) begin
         @(negedge clk);
         if (bus.req_ready_o) begin
            expQ.push_back(e);
            accepted = 1'b1;
            if (op == MUL_OP) lastCtrl = ALU_ADD;
            else if (e.err == 1'b0) lastCtrl = op;
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid_i = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: actual=not accepted required=accepted op=%h", op);
      end
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: actual=%0d pending required=0", expQ.size());
         expQ.delete();
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
      checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
      checkOutput({tag, "_rsp_result"}, bus.rsp_result_o, 32'd0);
      checkOutput({tag, "_rsp_zero"}, 32'(bus.rsp_zero_o), 32'd0);
      checkOutput({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
      checkOutput({tag, "_alu_src1"}, bus.alu_src1_o, 32'd0);
      checkOutput({tag, "_alu_src2"}, bus.alu_src2_o, 32'd0);
      checkOutput({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl_o), 32'd0);
   endtask

   initial begin
      bus.req_valid_i = 1'b0;
      bus.req_op_i    = 4'd0;
      bus.req_a_i     = 32'd0;
      bus.req_b_i     = 32'd0;
      #23;
      checkResetValues("reset");
      #9;
      rstN = 1'b1;
      $display("[TB] reset released");

      // Directed operations
      applyStimulus(ALU_ADD, 32'd7, 32'd5);
      applyStimulus(ALU_SUB, 32'd9, 32'd9);
      applyStimulus(ALU_SLT, 32'd3, 32'd8);
      applyStimulus(MUL_OP, 32'h0001_0001, 32'h0000_FFFF);
      applyStimulus(MUL_OP, 32'h8000_0000, 32'd2);
      waitDrain();
      applyStimulus(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
      waitDrain();
      @(negedge clk);
      checkOutput("illegal_ctrl_hold", 32'(bus.alu_ctrl_o), 32'(lastCtrl));

      // Backpressure: response held while a competing request is presented
      readyMode = 0;
      @(posedge clk);
      applyStimulus(ALU_ADD, 32'd100, 32'd23);
      for (int i = 0; i < 20 && !bus.rsp_valid_o; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.req_valid_i = 1'b1;
         bus.req_op_i    = ALU_OR;
         bus.req_a_i     = 32'h0F0F_0000;
         bus.req_b_i     = 32'h0000_00F0;
         @(negedge clk);
         checkOutput("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
         checkOutput("bp_rsp_result", bus.rsp_result_o, 32'd123);
         checkOutput("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      readyMode = 1;
      waitDrain();
      repeat (3) @(negedge clk);
      checkOutput("bp_no_extra_rsp", 32'(bus.rsp_valid_o), 32'd0);

      // Asynchronous reset in the middle of a multiply
      applyStimulus(MUL_OP, 32'h1234_5678, 32'h0000_0FFF);
      repeat (10) @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      checkResetValues("midmul");
      expQ.delete();
      lastCtrl = 4'b0000;
      @(negedge clk);
      #2;
      rstN = 1'b1;
      applyStimulus(ALU_ADD, 32'd1, 32'd1);
      waitDrain();

      // Randomised mix with random response backpressure
      readyMode = 2;
      for (int n = 0; n < 30; n++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 6) op = legalOps[sel];
         else if (sel < 8) op = MUL_OP;
         else op = illegalOps[$urandom_range(0, 8)];
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
         applyStimulus(op, a, b);
      end
      waitDrain();
      readyMode = 1;
      repeat (3) @(negedge clk);
      checkOutput("final_idle_ready", 32'(bus.req_ready_o), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
